counter_mod_seg: RTL and testbench

Parametrised modulo-N up/down counter with enable prescaler, synchronous load, terminal-count pulse and a seven-segment display output. It is the general successor of the fixed 3-bit display counter.
- Width, modulus, count rate and segment polarity are set per instance.
- The block drives board LEDs/7-seg digits directly.
- It also serves as a cascadable digit counter: `oTc` of one stage drives `iEn` of the next.

---
 rtl/counter_pkg.sv | 42 ++++
 rtl/seg7_decoder.sv | 28 ++
 rtl/counter_mod_seg.sv | 95 +++++++++
 tb/tb_counter_mod_seg.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared seven-segment code table and segment bit positions.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package counter_pkg;

   // Segment bit positions within the {g,f,e,d,c,b,a} display bus
   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   // Active-low hex codes, entry n is the pattern for digit n (F in the top slot)
   localparam logic [15:0][6:0] SEG7_CODE_AL = {
      7'b0001110,  // F
      7'b0000110,  // E
      7'b0100001,  // d
      7'b1000110,  // C
      7'b0000011,  // b
      7'b0001000,  // A
      7'b0010000,  // 9
      7'b0000000,  // 8
      7'b1111000,  // 7
      7'b0000010,  // 6
      7'b0010010,  // 5
      7'b0011001,  // 4
      7'b0110000,  // 3
      7'b0100100,  // 2
      7'b1111001,  // 1
      7'b1000000   // 0
   };

   // Pattern for a nibble in the requested polarity (active-high is the bitwise inverse)
   function automatic logic [6:0] seg7_encode(input logic [3:0] v, input bit active_low);
      logic [6:0] code;
      code = SEG7_CODE_AL[v];
      return active_low ? code : ~code;
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: hex nibble to seven-segment pattern, polarity set by ACTIVE_LOW.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output always follows input.
module seg7_decoder
   import counter_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic [3:0] i_val,
   output logic [6:0] o_seg
);

   logic [6:0] w_code;

   // Look up the pattern, then place each segment explicitly on its named bit
   always_comb begin
      w_code       = seg7_encode(i_val, ACTIVE_LOW);
      o_seg        = '0;
      o_seg[SEG_A] = w_code[SEG_A];
      o_seg[SEG_B] = w_code[SEG_B];
      o_seg[SEG_C] = w_code[SEG_C];
      o_seg[SEG_D] = w_code[SEG_D];
      o_seg[SEG_E] = w_code[SEG_E];
      o_seg[SEG_F] = w_code[SEG_F];
      o_seg[SEG_G] = w_code[SEG_G];
   end

endmodule

// File: rtl/counter_mod_seg.sv
// counter_mod_seg: modulo-N up/down counter with prescaled enable, load, wrap pulse, 7-seg out.
// Latency: load/step take effect on the next edge; a step needs PRESCALE enabled edges; display is combinational.
// Backpressure: none; iEn gates progress, so oTc of one stage can drive iEn of the next.
module counter_mod_seg
   import counter_pkg::*;
#(
   parameter int WIDTH          = 4,
   parameter int MODULUS        = 16,
   parameter int PRESCALE       = 1,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic             CLK,
   input  logic             rst_n,
   input  logic             iEn,
   input  logic             iUp,
   input  logic             iLoad,
   input  logic [WIDTH-1:0] iD,
   output logic [WIDTH-1:0] oQ,
   output logic             oTc,
   output logic [6:0]       oDisplay
);

   localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] Q_LAST  = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   logic [WIDTH-1:0] r_q;
   logic [PS_W-1:0]  r_ps;
   logic             r_tc;

   logic             w_ps_last;
   logic             w_at_last;
   logic             w_at_zero;
   logic [WIDTH-1:0] w_load_val;
   logic [3:0]       w_nibble;

   // Step/wrap qualifiers; out-of-range load values collapse to 0.
   // MODULUS need not be a power of two, so wraps compare against MODULUS-1 explicitly.
   always_comb begin
      w_ps_last  = (r_ps == PS_LAST);
      w_at_last  = (r_q == Q_LAST);
      w_at_zero  = (r_q == '0);
      w_load_val = ({1'b0, iD} < MOD_EXT) ? iD : '0;
   end

   // Count, prescaler and wrap-pulse registers; load beats enable, enable beats hold
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         r_q  <= '0;
         r_ps <= '0;
         r_tc <= 1'b0;
      end else if (iLoad) begin
         r_q  <= w_load_val;
         r_ps <= '0;
         r_tc <= 1'b0;
      end else if (iEn) begin
         if (w_ps_last) begin
            r_ps <= '0;
            if (iUp) begin
               r_q  <= w_at_last ? '0 : r_q + WIDTH'(1);
               r_tc <= w_at_last;
            end else begin
               r_q  <= w_at_zero ? Q_LAST : r_q - WIDTH'(1);
               r_tc <= w_at_zero;
            end
         end else begin
            r_ps <= r_ps + PS_W'(1);
            r_tc <= 1'b0;
         end
      end else begin
         r_tc <= 1'b0;
      end
   end

   // Only the low nibble is displayed; narrow counters are zero-extended
   generate
      if (WIDTH >= 4) begin : g_nib_wide
         assign w_nibble = r_q[3:0];
      end else begin : g_nib_narrow
         assign w_nibble = 4'(r_q);
      end
   endgenerate

   seg7_decoder #(
      .ACTIVE_LOW(SEG_ACTIVE_LOW)
   ) u_seg7 (
      .i_val(w_nibble),
      .o_seg(oDisplay)
   );

   assign oQ  = r_q;
   assign oTc = r_tc;

endmodule

// File: tb/tb_counter_mod_seg.sv
// tb_counter_mod_seg: several parameterisations driven in lockstep against a modulo-arithmetic model.
// Latency: outputs sampled 2 ns after each rising edge.
// Backpressure: n/a.
module tb_counter_mod_seg;

   localparam int N = 5;
   // Per-instance parameters, same order as the instances below
   localparam int P_W [N] = '{4, 3, 4, 4, 5};
   localparam int P_M [N] = '{16, 8, 10, 16, 20};
   localparam int P_P [N] = '{1, 1, 1, 3, 2};
   localparam int P_AL[N] = '{1, 1, 1, 1, 0};

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic       rst_n, iEn, iUp, iLoad;
   logic [7:0] iD;

   logic [3:0] q0, q2, q3;
   logic [2:0] q1;
   logic [4:0] q4;
   logic [N-1:0]      tcv;
   logic [N-1:0][6:0] segv;
   logic [N-1:0][7:0] qv;

   assign qv[0] = 8'(q0);
   assign qv[1] = 8'(q1);
   assign qv[2] = 8'(q2);
   assign qv[3] = 8'(q3);
   assign qv[4] = 8'(q4);

   counter_mod_seg #(.WIDTH(4), .MODULUS(16), .PRESCALE(1), .SEG_ACTIVE_LOW(1'b1)) u_def (
      .CLK(CLK), .rst_n(rst_n), .iEn(iEn), .iUp(iUp), .iLoad(iLoad), .iD(iD[3:0]),
      .oQ(q0), .oTc(tcv[0]), .oDisplay(segv[0]));
   counter_mod_seg #(.WIDTH(3), .MODULUS(8), .PRESCALE(1), .SEG_ACTIVE_LOW(1'b1)) u_w3 (
      .CLK(CLK), .rst_n(rst_n), .iEn(iEn), .iUp(iUp), .iLoad(iLoad), .iD(iD[2:0]),
      .oQ(q1), .oTc(tcv[1]), .oDisplay(segv[1]));
   counter_mod_seg #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SEG_ACTIVE_LOW(1'b1)) u_m10 (
      .CLK(CLK), .rst_n(rst_n), .iEn(iEn), .iUp(iUp), .iLoad(iLoad), .iD(iD[3:0]),
      .oQ(q2), .oTc(tcv[2]), .oDisplay(segv[2]));
   counter_mod_seg #(.WIDTH(4), .MODULUS(16), .PRESCALE(3), .SEG_ACTIVE_LOW(1'b1)) u_ps3 (
      .CLK(CLK), .rst_n(rst_n), .iEn(iEn), .iUp(iUp), .iLoad(iLoad), .iD(iD[3:0]),
      .oQ(q3), .oTc(tcv[3]), .oDisplay(segv[3]));
   counter_mod_seg #(.WIDTH(5), .MODULUS(20), .PRESCALE(2), .SEG_ACTIVE_LOW(1'b0)) u_hi (
      .CLK(CLK), .rst_n(rst_n), .iEn(iEn), .iUp(iUp), .iLoad(iLoad), .iD(iD[4:0]),
      .oQ(q4), .oTc(tcv[4]), .oDisplay(segv[4]));

   // Active-low display table, digit 0..F
   logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   int checks = 0;
   int errors = 0;

   // Reference model: count value, enabled-edge tally since last step, wrap flag
   int m_q [N];
   int m_ps[N];
   bit m_tc[N];

   function automatic logic [6:0] exp_seg(input int k);
      logic [6:0] c;
      c = seg_tab[m_q[k] % 16];
      return (P_AL[k] != 0) ? c : ~c;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         m_q[k] = 0; m_ps[k] = 0; m_tc[k] = 1'b0;
      end
   endtask

   task automatic model_edge();
      int d;
      for (int k = 0; k < N; k++) begin
         d = int'(iD) % (1 << P_W[k]);
         m_tc[k] = 1'b0;
         if (iLoad) begin
            m_q[k]  = (d < P_M[k]) ? d : 0;
            m_ps[k] = 0;
         end else if (iEn) begin
            m_ps[k] = m_ps[k] + 1;
            if (m_ps[k] == P_P[k]) begin
               m_ps[k] = 0;
               if (iUp) begin
                  m_tc[k] = (m_q[k] + 1 == P_M[k]);
                  m_q[k]  = (m_q[k] + 1) % P_M[k];
               end else begin
                  m_tc[k] = (m_q[k] == 0);
                  m_q[k]  = (m_q[k] + P_M[k] - 1) % P_M[k];
               end
            end
         end
      end
   endtask

   task automatic clk_edge();
      @(posedge CLK);
      model_edge();
      #2;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; iEn = 1'b0; iUp = 1'b1; iLoad = 1'b0; iD = '0;
      model_reset();
      #4;
      for (int k = 0; k < N; k++) begin
         checks++;
         if (qv[k] !== 8'd0 || tcv[k] !== 1'b0) begin
            errors++;
            $display("FAIL reset_state inst%0d q=%0d tc=%b want q=0 tc=0", k, qv[k], tcv[k]);
         end
         checks++;
         if (segv[k] !== ((P_AL[k] != 0) ? 7'b1000000 : 7'b0111111)) begin
            errors++;
            $display("FAIL reset_display inst%0d got %b", k, segv[k]);
         end
      end
      #8;
      rst_n = 1'b1;
   endtask

   task automatic test_default_run();
      iEn = 1'b1; iUp = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         clk_edge();
         checks++;
         if (qv[0] !== 8'(i % 16) || tcv[0] !== (i == 16)) begin
            errors++;
            $display("FAIL def_run edge%0d q=%0d tc=%b want q=%0d tc=%b", i, qv[0], tcv[0], i % 16, i == 16);
         end
         checks++;
         if (qv[1] !== 8'(i % 8) || tcv[1] !== (i % 8 == 0)) begin
            errors++;
            $display("FAIL w3_run edge%0d q=%0d tc=%b want %0d", i, qv[1], tcv[1], i % 8);
         end
         checks++;
         if (qv[3] !== 8'(i / 3)) begin
            errors++;
            $display("FAIL ps3_run edge%0d q=%0d want %0d", i, qv[3], i / 3);
         end
         if (i == 15) begin
            checks++;
            if (segv[0] !== 7'b0001110) begin
               errors++;
               $display("FAIL disp_F got %b want 0001110", segv[0]);
            end
         end
         if (i % 8 == 7) begin
            checks++;
            if (segv[1] !== 7'b1111000) begin
               errors++;
               $display("FAIL disp_7 got %b want 1111000", segv[1]);
            end
         end
      end
   endtask

   task automatic test_down_m10();
      int exp_q[5] = '{2, 1, 0, 9, 8};
      iLoad = 1'b1; iD = 8'd3; iEn = 1'b0;
      clk_edge();
      checks++;
      if (qv[2] !== 8'd3) begin
         errors++;
         $display("FAIL dn_load q=%0d want 3", qv[2]);
      end
      iLoad = 1'b0; iEn = 1'b1; iUp = 1'b0;
      for (int i = 0; i < 5; i++) begin
         clk_edge();
         checks++;
         if (qv[2] !== 8'(exp_q[i]) || tcv[2] !== (exp_q[i] == 9)) begin
            errors++;
            $display("FAIL dn_step%0d q=%0d tc=%b want q=%0d tc=%b", i, qv[2], tcv[2], exp_q[i], exp_q[i] == 9);
         end
      end
   endtask

   task automatic test_prescale_gap();
      iLoad = 1'b1; iD = 8'd0; iEn = 1'b0; iUp = 1'b1;
      clk_edge();
      iLoad = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         iEn = (e >= 2 && e <= 5) ? 1'b0 : 1'b1;
         clk_edge();
         checks++;
         if (qv[3] !== ((e == 7) ? 8'd1 : 8'd0)) begin
            errors++;
            $display("FAIL ps_gap edge%0d q=%0d want %0d", e, qv[3], (e == 7) ? 1 : 0);
         end
      end
   endtask

   task automatic test_load_edges();
      iEn = 1'b0; iLoad = 1'b1; iD = 8'd12;
      clk_edge();
      checks++;
      if (qv[2] !== 8'd0) begin
         errors++;
         $display("FAIL load_over q=%0d want 0", qv[2]);
      end
      iD = 8'd9;
      clk_edge();
      iLoad = 1'b0; iEn = 1'b1; iUp = 1'b1;
      clk_edge();
      checks++;
      if (qv[2] !== 8'd0 || tcv[2] !== 1'b1) begin
         errors++;
         $display("FAIL wrap_up q=%0d tc=%b want q=0 tc=1", qv[2], tcv[2]);
      end
      iLoad = 1'b1; iEn = 1'b0; iD = 8'd9;
      clk_edge();
      iEn = 1'b1; iD = 8'd5;
      clk_edge();
      checks++;
      if (qv[2] !== 8'd5 || tcv[2] !== 1'b0) begin
         errors++;
         $display("FAIL load_vs_wrap q=%0d tc=%b want q=5 tc=0", qv[2], tcv[2]);
      end
      iLoad = 1'b0; iEn = 1'b0;
   endtask

   task automatic test_async_reset();
      iLoad = 1'b1; iD = 8'd6; iEn = 1'b0;
      clk_edge();
      iLoad = 1'b0;
      checks++;
      if (qv[0] !== 8'd6) begin
         errors++;
         $display("FAIL ar_preload q=%0d want 6", qv[0]);
      end
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (qv[0] !== 8'd0 || segv[0] !== 7'b1000000 || tcv[0] !== 1'b0) begin
         errors++;
         $display("FAIL ar_immediate q=%0d seg=%b tc=%b want 0 1000000 0", qv[0], segv[0], tcv[0]);
      end
      #1 rst_n = 1'b1;
      iEn = 1'b1; iUp = 1'b1;
      clk_edge();
      checks++;
      if (qv[0] !== 8'd1) begin
         errors++;
         $display("FAIL ar_restart q=%0d want 1", qv[0]);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         iEn   = ($urandom_range(0, 3) != 0);
         iUp   = ($urandom_range(0, 4) != 0);
         iLoad = ($urandom_range(0, 15) == 0);
         iD    = 8'($urandom);
         clk_edge();
         for (int k = 0; k < N; k++) begin
            checks++;
            if (qv[k] !== 8'(m_q[k]) || tcv[k] !== m_tc[k] || segv[k] !== exp_seg(k)) begin
               errors++;
               $display("FAIL rnd inst%0d cyc%0d q=%0d tc=%b seg=%b want q=%0d tc=%b seg=%b",
                        k, i, qv[k], tcv[k], segv[k], m_q[k], m_tc[k], exp_seg(k));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_default_run();
      test_down_m10();
      test_prescale_gap();
      test_load_edges();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
